fp_itos: RTL and testbench
==========================

// Module: fp_itos
// PURPOSE
//  Pipelined conversion of a 32-bit two's-complement integer to an IEEE-754 single (SPARC FiTOs).
//  Inverse of the float-to-integer units in the FPU.
//  Fully pipelined: one conversion per cycle, fixed latency 5, no stall or back-pressure.
//  The FPU issue logic drives en/din; the writeback logic consumes rdy/dout/inexact.
// PARAMETERS
//  (none) -- widths fixed: 32-bit signed in, 32-bit single out; latency fixed at 5.
// PORTS
//  clk       in   1   rising-edge clock
//  rst       in   1   asynchronous active-high reset
//  en        in   1   operation valid; din/rnd_mode sampled when 1
//  din       in   32  signed integer operand
//  rnd_mode  in   2   FSR.RD: 0 nearest-even, 1 toward zero, 2 toward +inf, 3 toward -inf
//  dout      out  32  single-precision result
//  rdy       out  1   dout/inexact valid this cycle (single-cycle pulse per op)
//  inexact   out  1   result was rounded (NX); valid with rdy
// BEHAVIOUR
//  Reset: one clock, asynchronous, active-high. All stage-valid bits, rdy, dout, inexact -> 0.
//  Reset mid-operation: in-flight ops are dropped and never produce rdy.
//  Latency: en=1 sampled at edge k -> rdy=1 after edge k+5.
//  Back-to-back en gives back-to-back rdy; order is preserved.
//  Pipeline; each stage carries valid, sign, zero flag and rnd_mode:
//   S1: sign=din[31]; mag = sign ? (~din+1) : din, as 32-bit unsigned.
//       0x80000000 gives mag=0x80000000. zero=(din==0).
//   S2: lz = leading-zero count of mag (0..31); mag passed through.
//   S3: norm = mag << lz, so norm[31]=1 unless zero.
//   S4: frac=norm[30:8]; guard=norm[7]; sticky=|norm[6:0]; exp=158-lz (8 bits).
//       Increment decision inc:
//        RN: guard & (sticky | frac[0])
//        RZ: 0
//        +inf: ~sign & (guard|sticky)
//        -inf: sign & (guard|sticky)
//       {exp,frac} += inc, as one 31-bit add so a frac carry bumps exp (0x7FFFFF+1 -> exp+1, frac 0).
//       nx = guard|sticky. Max exp is 158, so no overflow/inf is possible.
//   S5: on valid: dout = zero ? 32'h0 : {sign,exp,frac}; inexact = zero ? 0 : nx.
//       rdy = valid.
//  din==0 -> +0.0 in every rounding mode, never -0.0.
//  |din| < 2^24 is always exact: inexact=0.
//  dout/inexact hold their last value while rdy=0. rdy is registered, never combinational from en.
//  No invalid or overflow outputs: FiTOs can raise only NX.
// TESTING
//  en, din=1, RN -> 5 cycles later rdy=1, dout=0x3F800000, inexact=0.
//    Also din=-1 -> dout=0xBF800000.
//  din=0, each rnd_mode -> dout=0x00000000, inexact=0.
//    Also din=0x80000000 -> dout=0xCF000000, inexact=0.
//  din=0x7FFFFFFF:
//    RN -> 0x4F000000, inexact=1
//    RZ -> 0x4EFFFFFF, inexact=1
//    +inf -> 0x4F000000
//    -inf -> 0x4EFFFFFF
//  din=0x01000001:
//    RN -> 0x4B800000 (tie to even)
//    +inf -> 0x4B800001
//    both inexact=1
//    din=0x01000003 RN -> 0x4B800002 (tie rounds up to even).
//  Stream en=1 for 20 cycles with random din/rnd_mode:
//    20 consecutive rdy pulses, in order, matching the reference model.
//    Then assert rst while 3 ops are in flight -> no rdy pulses; outputs read 0 after reset.

Source files
------------

// File: rtl/fp_itos.sv
// fp_itos: pipelined 32-bit signed integer to IEEE-754 single conversion (FiTOs).
// One conversion per cycle, fixed latency of five cycles from the capturing
// edge to rdy, no stall. Only the inexact flag can be raised.
module fp_itos (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] din,
  input  logic [1:0]  rnd_mode,
  output logic [31:0] dout,
  output logic        rdy,
  output logic        inexact
);

  localparam logic [1:0] RM_NEAREST = 2'd0;
  localparam logic [1:0] RM_ZERO    = 2'd1;
  localparam logic [1:0] RM_POS     = 2'd2;
  localparam logic [1:0] RM_NEG     = 2'd3;

  // Input capture
  logic        v0_q, v0_d;
  logic [31:0] din0_q, din0_d;
  logic [1:0]  rm0_q, rm0_d;

  // S1: sign / magnitude
  logic        v1_q, v1_d;
  logic        sign1_q, sign1_d;
  logic        zero1_q, zero1_d;
  logic [1:0]  rm1_q, rm1_d;
  logic [31:0] mag1_q, mag1_d;

  // S2: leading-zero count
  logic        v2_q, v2_d;
  logic        sign2_q, sign2_d;
  logic        zero2_q, zero2_d;
  logic [1:0]  rm2_q, rm2_d;
  logic [31:0] mag2_q, mag2_d;
  logic [4:0]  lz2_q, lz2_d;

  // S3: normalisation
  logic        v3_q, v3_d;
  logic        sign3_q, sign3_d;
  logic        zero3_q, zero3_d;
  logic [1:0]  rm3_q, rm3_d;
  logic [31:0] norm3_q, norm3_d;
  logic [4:0]  lz3_q, lz3_d;

  // S4: rounding
  logic        v4_q, v4_d;
  logic        sign4_q, sign4_d;
  logic        zero4_q, zero4_d;
  logic [30:0] expfrac4_q, expfrac4_d;
  logic        nx4_q, nx4_d;
  logic [22:0] s4_frac;
  logic        s4_guard;
  logic        s4_sticky;
  logic [7:0]  s4_exp;
  logic        s4_inc;

  // S5: output registers
  logic        rdy_q, rdy_d;
  logic [31:0] dout_q, dout_d;
  logic        inexact_q, inexact_d;

  // Capture the operand when issue logic presents a valid operation
  always_comb begin
    v0_d   = en;
    din0_d = din0_q;
    rm0_d  = rm0_q;
    if (en) begin
      din0_d = din;
      rm0_d  = rnd_mode;
    end
  end

  // Split into sign and unsigned magnitude; the most negative value maps to 2^31
  always_comb begin
    v1_d    = v0_q;
    sign1_d = din0_q[31];
    zero1_d = (din0_q == 32'd0);
    rm1_d   = rm0_q;
    mag1_d  = din0_q[31] ? (~din0_q + 32'd1) : din0_q;
  end

  // Count leading zeros; the highest set bit is the last one to assign
  always_comb begin
    v2_d    = v1_q;
    sign2_d = sign1_q;
    zero2_d = zero1_q;
    rm2_d   = rm1_q;
    mag2_d  = mag1_q;
    lz2_d   = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag1_q[i]) lz2_d = 5'(31 - i);
    end
  end

  // Shift the magnitude so the leading one lands in bit 31
  always_comb begin
    v3_d    = v2_q;
    sign3_d = sign2_q;
    zero3_d = zero2_q;
    rm3_d   = rm2_q;
    lz3_d   = lz2_q;
    norm3_d = mag2_q << lz2_q;
  end

  // Extract fraction/guard/sticky, decide the increment and add it across exp and frac
  always_comb begin
    v4_d      = v3_q;
    sign4_d   = sign3_q;
    zero4_d   = zero3_q;
    s4_frac   = norm3_q[30:8];
    s4_guard  = norm3_q[7];
    s4_sticky = |norm3_q[6:0];
    s4_exp    = 8'd158 - {3'b000, lz3_q};
    s4_inc    = 1'b0;
    case (rm3_q)
      RM_NEAREST: s4_inc = s4_guard & (s4_sticky | s4_frac[0]);
      RM_ZERO:    s4_inc = 1'b0;
      RM_POS:     s4_inc = ~sign3_q & (s4_guard | s4_sticky);
      RM_NEG:     s4_inc = sign3_q & (s4_guard | s4_sticky);
      default:    s4_inc = 1'b0;
    endcase
    expfrac4_d = {s4_exp, s4_frac} + {30'd0, s4_inc};
    nx4_d      = s4_guard | s4_sticky;
  end

  // Pack the result; zero always yields +0.0 and outputs hold between results
  always_comb begin
    rdy_d     = v4_q;
    dout_d    = dout_q;
    inexact_d = inexact_q;
    if (v4_q) begin
      dout_d    = zero4_q ? 32'h0000_0000 : {sign4_q, expfrac4_q};
      inexact_d = zero4_q ? 1'b0 : nx4_q;
    end
  end

  // Pipeline registers; reset drops everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q       <= 1'b0;
      din0_q     <= 32'd0;
      rm0_q      <= 2'd0;
      v1_q       <= 1'b0;
      sign1_q    <= 1'b0;
      zero1_q    <= 1'b0;
      rm1_q      <= 2'd0;
      mag1_q     <= 32'd0;
      v2_q       <= 1'b0;
      sign2_q    <= 1'b0;
      zero2_q    <= 1'b0;
      rm2_q      <= 2'd0;
      mag2_q     <= 32'd0;
      lz2_q      <= 5'd0;
      v3_q       <= 1'b0;
      sign3_q    <= 1'b0;
      zero3_q    <= 1'b0;
      rm3_q      <= 2'd0;
      norm3_q    <= 32'd0;
      lz3_q      <= 5'd0;
      v4_q       <= 1'b0;
      sign4_q    <= 1'b0;
      zero4_q    <= 1'b0;
      expfrac4_q <= 31'd0;
      nx4_q      <= 1'b0;
      rdy_q      <= 1'b0;
      dout_q     <= 32'd0;
      inexact_q  <= 1'b0;
    end else begin
      v0_q       <= v0_d;
      din0_q     <= din0_d;
      rm0_q      <= rm0_d;
      v1_q       <= v1_d;
      sign1_q    <= sign1_d;
      zero1_q    <= zero1_d;
      rm1_q      <= rm1_d;
      mag1_q     <= mag1_d;
      v2_q       <= v2_d;
      sign2_q    <= sign2_d;
      zero2_q    <= zero2_d;
      rm2_q      <= rm2_d;
      mag2_q     <= mag2_d;
      lz2_q      <= lz2_d;
      v3_q       <= v3_d;
      sign3_q    <= sign3_d;
      zero3_q    <= zero3_d;
      rm3_q      <= rm3_d;
      norm3_q    <= norm3_d;
      lz3_q      <= lz3_d;
      v4_q       <= v4_d;
      sign4_q    <= sign4_d;
      zero4_q    <= zero4_d;
      expfrac4_q <= expfrac4_d;
      nx4_q      <= nx4_d;
      rdy_q      <= rdy_d;
      dout_q     <= dout_d;
      inexact_q  <= inexact_d;
    end
  end

  assign rdy     = rdy_q;
  assign dout    = dout_q;
  assign inexact = inexact_q;

endmodule

// File: tb/tb_fp_itos.sv
// Testbench for fp_itos: directed vectors plus random streams, checked through
// a scoreboard queue against an arithmetic reference model.
module tb_fp_itos;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] din;
  logic [1:0]  rnd_mode;
  logic [31:0] dout;
  logic        rdy;
  logic        inexact;

  typedef struct {
    logic [31:0] dout;
    logic        nx;
    int          due;
    logic [31:0] din;
    logic [1:0]  rm;
  } exp_t;

  exp_t scoreboard[$];
  int   cyc;
  int   nCompared;
  int   nFailed;

  fp_itos dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .din      (din),
    .rnd_mode (rnd_mode),
    .dout     (dout),
    .rdy      (rdy),
    .inexact  (inexact)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count active edges so latency can be checked
  always @(posedge clk) cyc <= cyc + 1;

  // Reference conversion: locate the leading power of two, keep 24 significant
  // bits and round the discarded remainder against half a unit in the last place
  function automatic logic [32:0] refConvert(input logic [31:0] x, input logic [1:0] rm);
    logic               sgn;
    longint unsigned    mag;
    longint unsigned    q;
    longint unsigned    rem;
    longint unsigned    half;
    int                 e;
    int                 sh;
    logic               up;
    logic [7:0]         bexp;
    logic [23:0]        qq;
    sgn = x[31];
    mag = sgn ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
    if (mag == 0) return 33'd0;
    e = 0;
    for (int i = 0; i < 32; i++) if (mag >= (64'd1 << i)) e = i;
    if (e <= 23) begin
      q   = mag << (23 - e);
      rem = 0;
      half = 1;
    end else begin
      sh   = e - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 64'd1 << (sh - 1);
    end
    case (rm)
      2'd0:    up = (rem > half) || ((rem == half) && q[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = !sgn && (rem != 0);
      default: up = sgn && (rem != 0);
    endcase
    if (up) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      e = e + 1;
    end
    bexp = 8'(e + 127);
    qq   = q[23:0];
    return {(rem != 0), sgn, bexp, qq[22:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nCompared++;
    if (act !== req) begin
      nFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Drive one operation and push the expected result (explicit or from the model)
  task automatic applyStimulus(input logic [31:0] d, input logic [1:0] rm,
                               input bit useConst, input logic [31:0] cDout, input logic cNx);
    exp_t e;
    logic [32:0] r;
    @(posedge clk);
    #1;
    en       = 1'b1;
    din      = d;
    rnd_mode = rm;
    r = refConvert(d, rm);
    e.dout = useConst ? cDout : r[31:0];
    e.nx   = useConst ? cNx : r[32];
    e.due  = cyc + 6;
    e.din  = d;
    e.rm   = rm;
    scoreboard.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      en = 1'b0;
      din = $urandom;
      rnd_mode = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic drain();
    int budget;
    budget = 40;
    while (scoreboard.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    checkOutput("drain_pending", 32'(scoreboard.size()), 32'd0);
  endtask

  // Monitor: every rdy pulse pops the oldest expectation and compares it
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rdy) begin
      if (scoreboard.size() == 0) begin
        nCompared++;
        nFailed++;
        $display("[TB] FAIL unexpected_rdy: got rdy=1 at cycle %0d, expected no pending op", cyc);
      end else begin
        e = scoreboard.pop_front();
        checkOutput($sformatf("dout din=%08h rm=%0d", e.din, e.rm), dout, e.dout);
        checkOutput($sformatf("inexact din=%08h rm=%0d", e.din, e.rm), {31'd0, inexact}, {31'd0, e.nx});
        checkOutput($sformatf("latency din=%08h", e.din), cyc, e.due);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    cyc = 0;
    nCompared = 0;
    nFailed = 0;
    en = 1'b0;
    din = 32'd0;
    rnd_mode = 2'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_rdy", {31'd0, rdy}, 32'd0);
    checkOutput("reset_dout", dout, 32'd0);
    checkOutput("reset_inexact", {31'd0, inexact}, 32'd0);

    // Directed vectors with values fixed by hand
    applyStimulus(32'd1,         2'd0, 1, 32'h3F80_0000, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 2'd0, 1, 32'hBF80_0000, 1'b0);
    for (int m = 0; m < 4; m++) applyStimulus(32'd0, 2'(m), 1, 32'h0000_0000, 1'b0);
    applyStimulus(32'h8000_0000, 2'd0, 1, 32'hCF00_0000, 1'b0);
    applyStimulus(32'h7FFF_FFFF, 2'd0, 1, 32'h4F00_0000, 1'b1);
    applyStimulus(32'h7FFF_FFFF, 2'd1, 1, 32'h4EFF_FFFF, 1'b1);
    applyStimulus(32'h7FFF_FFFF, 2'd2, 1, 32'h4F00_0000, 1'b1);
    applyStimulus(32'h7FFF_FFFF, 2'd3, 1, 32'h4EFF_FFFF, 1'b1);
    applyStimulus(32'h0100_0001, 2'd0, 1, 32'h4B80_0000, 1'b1);
    applyStimulus(32'h0100_0001, 2'd2, 1, 32'h4B80_0001, 1'b1);
    applyStimulus(32'h0100_0003, 2'd0, 1, 32'h4B80_0002, 1'b1);
    applyStimulus(32'hFEFF_FFFF, 2'd3, 1, 32'hCB80_0001, 1'b1);
    applyStimulus(32'h00FF_FFFF, 2'd2, 1, 32'h4B7F_FFFF, 1'b0);
    idle(3);
    drain();

    // Back-to-back random stream of 20 operations
    for (int i = 0; i < 20; i++)
      applyStimulus($urandom, 2'($urandom_range(0, 3)), 0, 32'd0, 1'b0);
    idle(1);
    drain();

    // Longer random traffic with gaps and small magnitudes mixed in
    for (int i = 0; i < 150; i++) begin
      logic [31:0] v;
      v = $urandom;
      if ($urandom_range(0, 3) == 0) v = 32'($signed(v) >>> $urandom_range(8, 30));
      applyStimulus(v, 2'($urandom_range(0, 3)), 0, 32'd0, 1'b0);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    drain();

    // Reset with three operations in flight: none of them may come out
    for (int i = 0; i < 3; i++)
      applyStimulus($urandom | 32'h0000_1000, 2'($urandom_range(0, 3)), 0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    en = 1'b0;
    rst = 1'b1;
    scoreboard.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_dout", dout, 32'd0);
    checkOutput("post_reset_inexact", {31'd0, inexact}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy) pulses++;
    end
    checkOutput("post_reset_rdy_pulses", pulses, 0);

    // Pipeline still works after the flush
    applyStimulus(32'hFFFF_FFF6, 2'd1, 1, 32'hC120_0000, 1'b0);
    idle(1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
